// File: rtl/audio_pkg.sv
// Shared types and constants for the voice allocator: state encoding and
// packed-volume slicing helpers.
package audio_pkg;

  localparam int DEF_KEY_W = 7;
  localparam int VOL_W     = 8;

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, REGATE} alloc_state_t;

  function automatic int vol_lsb(input int voice);
    return voice * VOL_W;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the CPU side and the voice allocator.
interface voice_allocator_if #(
  parameter int KEY_W = audio_pkg::DEF_KEY_W
);

  logic             note_valid;
  logic             note_ready;
  logic             note_on;
  logic [KEY_W-1:0] note_key;

  modport master (output note_valid, note_on, note_key, input note_ready);
  modport slave  (input note_valid, note_on, note_key, output note_ready);

endinterface

// File: rtl/voice_allocator_slot.sv
// Per-voice gate/key/start registers driven by set, clear and load strobes.
module voice_slot
  import audio_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_gate,
  input  logic             clr_gate,
  input  logic             load,
  input  logic [KEY_W-1:0] load_key,
  output logic             gate,
  output logic [KEY_W-1:0] key,
  output logic             start
);

  always_ff @(posedge clk) begin
    if (rst) begin
      gate  <= 1'b0;
      key   <= '0;
      start <= 1'b0;
    end else begin
      start <= load;
      if (load) key <= load_key;
      // Clear wins so a retrigger always produces a low gate cycle.
      if (clr_gate)      gate <= 1'b0;
      else if (set_gate) gate <= 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans one voice per cycle, then assigns a
// note-on (retrigger > free > releasing > round-robin steal) or releases a note-off.
module voice_allocator
  import audio_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int KEY_W   = DEF_KEY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  voice_allocator_if.slave         note,
  input  logic [NVOICES*8-1:0]     volume,
  output logic [NVOICES-1:0]       gate,
  output logic [NVOICES*KEY_W-1:0] voice_key,
  output logic [NVOICES-1:0]       voice_start,
  output logic                     stolen
);

  localparam int IDX_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NVOICES - 1);

  alloc_state_t state, next_state;

  logic [IDX_W-1:0] idx, steal_ptr, tgt;
  logic [IDX_W-1:0] match_idx, free_idx, rel_idx;
  logic             has_match, has_free, has_rel;
  logic             on_r;
  logic [KEY_W-1:0] key_r;

  logic [IDX_W-1:0]   apply_t;
  logic               apply_held, apply_steal, ready;
  logic [NVOICES-1:0] set_gate, clr_gate, load;
  logic [VOL_W-1:0]   vol_cur;
  logic [KEY_W-1:0]   key_cur;

  assign vol_cur         = volume[vol_lsb(int'(idx)) +: VOL_W];
  assign key_cur         = voice_key[int'(idx)*KEY_W +: KEY_W];
  assign note.note_ready = ready;

  always_comb begin
    apply_t     = steal_ptr;
    apply_held  = gate[steal_ptr];
    apply_steal = 1'b1;
    if (has_match) begin
      apply_t     = match_idx;
      apply_held  = 1'b1;
      apply_steal = 1'b0;
    end else if (has_free) begin
      apply_t     = free_idx;
      apply_held  = 1'b0;
      apply_steal = 1'b0;
    end else if (has_rel) begin
      apply_t     = rel_idx;
      apply_held  = 1'b0;
      apply_steal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    set_gate   = '0;
    clr_gate   = '0;
    load       = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (note.note_valid) next_state = SCAN;
      end
      SCAN: begin
        if (idx == LAST) next_state = APPLY;
      end
      APPLY: begin
        next_state = IDLE;
        if (on_r) begin
          load[apply_t] = 1'b1;
          if (apply_held) begin
            clr_gate[apply_t] = 1'b1;
            next_state        = REGATE;
          end else begin
            set_gate[apply_t] = 1'b1;
          end
        end else if (has_match) begin
          clr_gate[match_idx] = 1'b1;
        end
      end
      REGATE: begin
        set_gate[tgt] = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Candidate tracking keeps only the first (lowest-index) hit of each class.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      steal_ptr <= '0;
      tgt       <= '0;
      match_idx <= '0;
      free_idx  <= '0;
      rel_idx   <= '0;
      has_match <= 1'b0;
      has_free  <= 1'b0;
      has_rel   <= 1'b0;
      on_r      <= 1'b0;
      key_r     <= '0;
      stolen    <= 1'b0;
    end else begin
      stolen <= 1'b0;
      case (state)
        IDLE: begin
          if (note.note_valid) begin
            on_r      <= note.note_on;
            key_r     <= note.note_key;
            has_match <= 1'b0;
            has_free  <= 1'b0;
            has_rel   <= 1'b0;
            idx       <= '0;
          end
        end
        SCAN: begin
          if (gate[idx] && key_cur == key_r && !has_match) begin
            has_match <= 1'b1;
            match_idx <= idx;
          end
          if (!gate[idx] && vol_cur == '0 && !has_free) begin
            has_free <= 1'b1;
            free_idx <= idx;
          end
          if (!gate[idx] && vol_cur != '0 && !has_rel) begin
            has_rel <= 1'b1;
            rel_idx <= idx;
          end
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        APPLY: begin
          tgt <= apply_t;
          if (on_r && apply_steal) begin
            steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
            stolen    <= apply_held;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NVOICES; i++) begin : g_slot
    voice_slot #(.KEY_W(KEY_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .set_gate (set_gate[i]),
      .clr_gate (clr_gate[i]),
      .load     (load[i]),
      .load_key (key_r),
      .gate     (gate[i]),
      .key      (voice_key[i*KEY_W +: KEY_W]),
      .start    (voice_start[i])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: directed scenarios plus random note events compared
// against a per-event allocation model of the voice bank.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if #(.KEY_W(KW)) note_bus ();

  logic [NV*8-1:0]  volume;
  logic [NV-1:0]    gate;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0]    voice_start;
  logic             stolen;

  voice_allocator #(.NVOICES(NV), .KEY_W(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .note        (note_bus.slave),
    .volume      (volume),
    .gate        (gate),
    .voice_key   (voice_key),
    .voice_start (voice_start),
    .stolen      (stolen)
  );

  int total = 0;
  int bad   = 0;

  // Reference state of the voice bank
  bit   m_gate[NV];
  int   m_key[NV];
  int   m_vol[NV];
  int   m_sp;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gateVec();
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = m_gate[i];
    return v;
  endfunction

  function automatic logic [31:0] keyVec();
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v = v | (32'(m_key[i]) << (i * KW));
    return v;
  endfunction

  task automatic setVolume(input int i, input int v);
    logic [7:0] b;
    b = v[7:0];
    volume[i*8 +: 8] = b;
    m_vol[i] = v;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0;
      m_key[i]  = 0;
    end
    m_sp = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("rst_gate", 32'(gate), 32'd0);
    checkOutput("rst_key", 32'(voice_key), 32'd0);
    checkOutput("rst_start", 32'(voice_start), 32'd0);
    checkOutput("rst_stolen", 32'(stolen), 32'd0);
    checkOutput("rst_ready", 32'(note_bus.note_ready), 32'd1);
  endtask

  // Drives one event, predicts its outcome and checks it cycle by cycle.
  task automatic applyStimulus(input bit on, input int key);
    int t = -1;
    bit regate = 1'b0;
    bit stol = 1'b0;
    logic [31:0] exp_gate;
    logic [31:0] exp_start = '0;
    if (on) begin
      for (int i = 0; i < NV; i++)
        if (t < 0 && m_gate[i] && m_key[i] == key) begin t = i; regate = 1'b1; end
      for (int i = 0; i < NV; i++)
        if (t < 0 && !m_gate[i] && m_vol[i] == 0) t = i;
      for (int i = 0; i < NV; i++)
        if (t < 0 && !m_gate[i] && m_vol[i] != 0) t = i;
      if (t < 0) begin
        t = m_sp;
        m_sp = (m_sp + 1) % NV;
        regate = m_gate[t];
        stol = m_gate[t];
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (t < 0 && m_gate[i] && m_key[i] == key) t = i;
    end

    @(negedge clk);
    checkOutput("ready_idle", 32'(note_bus.note_ready), 32'd1);
    note_bus.note_valid = 1'b1;
    note_bus.note_on    = on;
    note_bus.note_key   = KW'(key);
    @(posedge clk);
    #1;
    note_bus.note_valid = 1'b0;

    for (int k = 1; k <= NV + 1; k++) begin
      @(negedge clk);
      checkOutput("ready_busy", 32'(note_bus.note_ready), 32'd0);
      checkOutput("start_quiet", 32'(voice_start), 32'd0);
    end

    if (on) begin
      m_key[t]  = key;
      m_gate[t] = 1'b1;
      exp_start[t] = 1'b1;
    end else if (t >= 0) begin
      m_gate[t] = 1'b0;
    end
    exp_gate = gateVec();
    if (regate) exp_gate[t] = 1'b0;

    @(negedge clk);
    checkOutput("gate_after", 32'(gate), exp_gate);
    checkOutput("key_after", 32'(voice_key), keyVec());
    checkOutput("start_pulse", 32'(voice_start), exp_start);
    checkOutput("stolen_pulse", 32'(stolen), 32'(stol));
    checkOutput("ready_after", 32'(note_bus.note_ready), 32'(!regate));
    if (regate) begin
      @(negedge clk);
      checkOutput("gate_regate", 32'(gate), gateVec());
      checkOutput("start_clear", 32'(voice_start), 32'd0);
      checkOutput("stolen_clear", 32'(stolen), 32'd0);
      checkOutput("ready_regate", 32'(note_bus.note_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    note_bus.note_valid = 1'b0;
    note_bus.note_on    = 1'b0;
    note_bus.note_key   = '0;
    volume = '0;
    for (int i = 0; i < NV; i++) m_vol[i] = 0;
    modelReset();

    // Reset, fill, then two round-robin steals
    doReset();
    applyStimulus(1'b1, 60);
    applyStimulus(1'b1, 62);
    applyStimulus(1'b1, 64);
    applyStimulus(1'b1, 67);
    checkOutput("fill_gates", 32'(gate), 32'hF);
    applyStimulus(1'b1, 72);
    applyStimulus(1'b1, 74);

    // Releasing voice preferred over stealing
    applyStimulus(1'b0, 74);
    setVolume(1, 40);
    applyStimulus(1'b1, 70);

    // Free voice preferred over releasing
    doReset();
    for (int i = 0; i < NV; i++) setVolume(i, 0);
    applyStimulus(1'b1, 60);
    applyStimulus(1'b1, 62);
    applyStimulus(1'b1, 64);
    applyStimulus(1'b0, 60);
    applyStimulus(1'b0, 64);
    setVolume(2, 10);
    applyStimulus(1'b1, 80);

    // Retrigger of a held key, then a note-off with no match
    applyStimulus(1'b1, 62);
    applyStimulus(1'b0, 99);

    // Reset during scan aborts the event
    doReset();
    for (int i = 0; i < NV; i++) setVolume(i, 0);
    applyStimulus(1'b1, 60);
    applyStimulus(1'b1, 62);
    applyStimulus(1'b1, 64);
    applyStimulus(1'b0, 60);
    checkOutput("pre_abort_gate", 32'(gate), 32'h6);
    @(negedge clk);
    note_bus.note_valid = 1'b1;
    note_bus.note_on    = 1'b1;
    note_bus.note_key   = KW'(70);
    @(posedge clk);
    #1;
    note_bus.note_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("abort_gate", 32'(gate), 32'd0);
    checkOutput("abort_ready", 32'(note_bus.note_ready), 32'd1);
    applyStimulus(1'b1, 50);

    // Random events over a small key range so matches and steals occur
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NV; i++)
        setVolume(i, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255)));
      applyStimulus($urandom_range(0, 9) < 7, 60 + int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
